io_bus_bridge: RTL and testbench

- Data-side bus bridge between the single-cycle core's data port and its memories and board peripherals.
- Decodes every core data access by address. The access goes either to the DRAM or to a memory-mapped I/O register block: LEDs, switches, 8-digit seven-segment display and an optional compare timer.
- Returns load data to the core in the same cycle, so single-cycle loads keep working.

---
 rtl/io_map_pkg.sv | 28 ++
 rtl/seg_scan.sv | 43 ++++
 rtl/io_bus_bridge.sv | 133 +++++++++++++
 tb/tb_io_bus_bridge.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// I/O page layout and seven-segment encoding shared by the data-side bridge.
// Constants only: no logic, no latency, no flow control.
package io_map_pkg;

    localparam logic [19:0] IO_PAGE  = 20'hFFFFF;
    localparam logic [11:0] OFF_SEG  = 12'h000;
    localparam logic [11:0] OFF_TCNT = 12'h040;
    localparam logic [11:0] OFF_TCMP = 12'h044;
    localparam logic [11:0] OFF_TCTL = 12'h048;
    localparam logic [11:0] OFF_LED  = 12'h060;
    localparam logic [11:0] OFF_SW   = 12'h070;

    localparam int TCTL_EN   = 0;
    localparam int TCTL_FLAG = 1;

    // Active-low {dp,g,f,e,d,c,b,a}; dp is always dark.
    function automatic logic [7:0] hex7(input logic [3:0] nib);
        logic [7:0] r;
        case (nib)
            4'h0: r = 8'hC0;  4'h1: r = 8'hF9;  4'h2: r = 8'hA4;  4'h3: r = 8'hB0;
            4'h4: r = 8'h99;  4'h5: r = 8'h92;  4'h6: r = 8'h82;  4'h7: r = 8'hF8;
            4'h8: r = 8'h80;  4'h9: r = 8'h90;  4'hA: r = 8'h88;  4'hB: r = 8'h83;
            4'hC: r = 8'hC6;  4'hD: r = 8'hA1;  4'hE: r = 8'h86;  default: r = 8'h8E;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg_scan.sv
// Multiplexes 8 hex digits onto the display, SCAN_DIV cycles per digit.
// Outputs registered: one cycle behind index/value; free-running, no backpressure.
module seg_scan
    import io_map_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] seg_val,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_cx
);

    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [DW-1:0] r_div;
    logic [2:0]    r_idx;
    logic [7:0]    r_an;
    logic [7:0]    r_cx;
    logic          w_last;

    assign w_last = (r_div == DW'(SCAN_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
            r_idx <= '0;
            r_an  <= 8'hFE;
            r_cx  <= 8'hC0;
        end else begin
            r_div <= w_last ? '0 : r_div + 1'b1;
            if (w_last)
                r_idx <= r_idx + 3'd1;
            r_an  <= ~(8'h01 << r_idx);
            r_cx  <= hex7(seg_val[r_idx*4 +: 4]);
        end
    end

    assign seg_an = r_an;
    assign seg_cx = r_cx;

endmodule

// File: rtl/io_bus_bridge.sv
// Routes core data accesses to DRAM or the I/O page; loads are combinational, stores land on the edge.
// No backpressure. Compare timer is built only when TIMER_EN is defined.
module io_bus_bridge
    import io_map_pkg::*;
#(
    parameter int DRAM_AW  = 14,
    parameter int SCAN_DIV = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        cpu_addr,
    input  logic               cpu_we,
    input  logic [31:0]        cpu_wdata,
    output logic [31:0]        cpu_rdata,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic               dram_we,
    output logic [31:0]        dram_wdata,
    input  logic [31:0]        dram_rdata,
    input  logic [23:0]        sw,
    output logic [23:0]        led,
    output logic [7:0]         seg_an,
    output logic [7:0]         seg_cx,
    output logic               timer_irq
);

    logic        w_io;
    logic        w_io_we;
    logic [11:0] w_off;
    logic [31:0] w_io_rdata;
    logic [31:0] w_tcnt_rd;
    logic [31:0] w_tcmp_rd;
    logic [31:0] w_tctl_rd;

    logic [31:0] r_seg;
    logic [23:0] r_led;
    logic [23:0] r_sw_meta;
    logic [23:0] r_sw_sync;

    assign w_io    = (cpu_addr[31:12] == IO_PAGE);
    assign w_off   = cpu_addr[11:0];
    assign w_io_we = cpu_we & w_io;

    assign dram_addr  = cpu_addr[DRAM_AW+1:2];
    assign dram_we    = cpu_we & ~w_io;
    assign dram_wdata = cpu_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg     <= '0;
            r_led     <= '0;
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
            if (w_io_we && w_off == OFF_SEG)
                r_seg <= cpu_wdata;
            if (w_io_we && w_off == OFF_LED)
                r_led <= cpu_wdata[23:0];
        end
    end

    assign led = r_led;

`ifdef TIMER_EN
    logic [31:0] r_tcnt;
    logic [31:0] r_tcmp;
    logic        r_en;
    logic        r_flag;
    logic        w_match;

    assign w_match = r_en && (r_tcnt == r_tcmp);

    // A CPU write to TCNT overrides counting; a match set overrides a write-1 clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tcnt <= '0;
            r_tcmp <= 32'hFFFF_FFFF;
            r_en   <= 1'b0;
            r_flag <= 1'b0;
        end else begin
            if (w_io_we && w_off == OFF_TCNT)
                r_tcnt <= cpu_wdata;
            else if (w_match)
                r_tcnt <= '0;
            else if (r_en)
                r_tcnt <= r_tcnt + 32'd1;
            if (w_io_we && w_off == OFF_TCMP)
                r_tcmp <= cpu_wdata;
            if (w_io_we && w_off == OFF_TCTL)
                r_en <= cpu_wdata[TCTL_EN];
            if (w_match)
                r_flag <= 1'b1;
            else if (w_io_we && w_off == OFF_TCTL && cpu_wdata[TCTL_FLAG])
                r_flag <= 1'b0;
        end
    end

    assign w_tcnt_rd = r_tcnt;
    assign w_tcmp_rd = r_tcmp;
    assign w_tctl_rd = {30'd0, r_flag, r_en};
    assign timer_irq = r_flag;
`else
    assign w_tcnt_rd = '0;
    assign w_tcmp_rd = '0;
    assign w_tctl_rd = '0;
    assign timer_irq = 1'b0;
`endif

    always_comb begin
        w_io_rdata = '0;
        case (w_off)
            OFF_SEG:  w_io_rdata = r_seg;
            OFF_TCNT: w_io_rdata = w_tcnt_rd;
            OFF_TCMP: w_io_rdata = w_tcmp_rd;
            OFF_TCTL: w_io_rdata = w_tctl_rd;
            OFF_LED:  w_io_rdata = {8'd0, r_led};
            OFF_SW:   w_io_rdata = {8'd0, r_sw_sync};
            default:  w_io_rdata = '0;
        endcase
    end

    assign cpu_rdata = w_io ? w_io_rdata : dram_rdata;

    seg_scan #(.SCAN_DIV(SCAN_DIV)) u_seg_scan (
        .clk     (clk),
        .rst     (rst),
        .seg_val (r_seg),
        .seg_an  (seg_an),
        .seg_cx  (seg_cx)
    );

endmodule

// File: tb/tb_io_bus_bridge.sv
// Directed bench for io_bus_bridge with a fast scan divider and a behavioural DRAM.
module tb_io_bus_bridge;

`ifdef TIMER_EN
    localparam bit TMR = 1'b1;
`else
    localparam bit TMR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] cpu_addr;
    logic        cpu_we;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic [13:0] dram_addr;
    logic        dram_we;
    logic [31:0] dram_wdata;
    logic [31:0] dram_rdata;
    logic [23:0] sw;
    logic [23:0] led;
    logic [7:0]  seg_an;
    logic [7:0]  seg_cx;
    logic        timer_irq;

    logic [31:0] mem [0:16383];

    int n_tests = 0;
    int n_fail  = 0;

    io_bus_bridge #(.DRAM_AW(14), .SCAN_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_we     (cpu_we),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .dram_addr  (dram_addr),
        .dram_we    (dram_we),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata),
        .sw         (sw),
        .led        (led),
        .seg_an     (seg_an),
        .seg_cx     (seg_cx),
        .timer_irq  (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk)
        if (dram_we) mem[dram_addr] <= dram_wdata;
    assign dram_rdata = mem[dram_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = 1'b1;
        tick();
        cpu_we    = 1'b0;
    endtask

    task automatic load(input string tag, input logic [31:0] a, input logic [31:0] exp);
        cpu_addr = a;
        #1;
        chk(tag, cpu_rdata, exp);
    endtask

    initial begin
        rst       = 1'b1;
        cpu_addr  = 32'h0;
        cpu_we    = 1'b0;
        cpu_wdata = 32'h0;
        sw        = 24'h0;
        #12;

        chk("rst_led",   {8'd0, led}, 32'h0);
        chk("rst_an",    {24'd0, seg_an}, 32'hFE);
        chk("rst_cx",    {24'd0, seg_cx}, 32'hC0);
        chk("rst_irq",   {31'd0, timer_irq}, 32'h0);
        load("rst_tcmp", 32'hFFFFF044, TMR ? 32'hFFFFFFFF : 32'h0);
        load("rst_seg",  32'hFFFFF000, 32'h0);

        // SEG write lands on edge 1; scanner counts from the same edge.
        cpu_addr  = 32'hFFFFF000;
        cpu_wdata = 32'h0000008A;
        cpu_we    = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        tick();
        cpu_we = 1'b0;
        chk("scan_e1_cx", {24'd0, seg_cx}, 32'hC0);
        tick();
        chk("scan_d0_an", {24'd0, seg_an}, 32'hFE);
        chk("scan_d0_cx", {24'd0, seg_cx}, 32'h88);
        for (int i = 0; i < 3; i++) tick();
        chk("scan_d1_an", {24'd0, seg_an}, 32'hFD);
        chk("scan_d1_cx", {24'd0, seg_cx}, 32'h80);
        for (int i = 0; i < 4; i++) tick();
        chk("scan_d2_an", {24'd0, seg_an}, 32'hFB);
        chk("scan_d2_cx", {24'd0, seg_cx}, 32'hC0);
        for (int i = 0; i < 23; i++) tick();
        chk("scan_d7_an", {24'd0, seg_an}, 32'h7F);
        tick();
        chk("scan_wrap_an", {24'd0, seg_an}, 32'hFE);
        chk("scan_wrap_cx", {24'd0, seg_cx}, 32'h88);

        // DRAM store/load
        cpu_addr  = 32'h00000010;
        cpu_wdata = 32'h12345678;
        cpu_we    = 1'b1;
        #1;
        chk("dram_we",   {31'd0, dram_we}, 32'h1);
        chk("dram_addr", {18'd0, dram_addr}, 32'h4);
        tick();
        cpu_we = 1'b0;
        load("dram_load", 32'h00000010, 32'h12345678);
        chk("led_untouched", {8'd0, led}, 32'h0);

        // LED and switch synchronizer
        store(32'hFFFFF060, 32'hFFA5A5A5);
        chk("led_drive", {8'd0, led}, 32'h00A5A5A5);
        load("led_read", 32'hFFFFF060, 32'h00A5A5A5);
        sw = 24'h00F00F;
        tick();
        load("sw_1edge", 32'hFFFFF070, 32'h0);
        tick();
        load("sw_2edge", 32'hFFFFF070, 32'h0000F00F);
        store(32'hFFFFF070, 32'h12345678);
        load("sw_ro", 32'hFFFFF070, 32'h0000F00F);

        // Unmapped I/O
        load("unmapped_rd", 32'hFFFFF080, 32'h0);
        cpu_wdata = 32'hDEADBEEF;
        cpu_we    = 1'b1;
        #1;
        chk("unmapped_dram_we", {31'd0, dram_we}, 32'h0);
        tick();
        cpu_we = 1'b0;
        load("unmapped_rd2", 32'hFFFFF080, 32'h0);
        load("dram_kept", 32'h00000010, 32'h12345678);

        // Timer: TCMP=3, enable, watch 0,1,2,3,0
        store(32'hFFFFF044, 32'h3);
        load("tcmp_rd", 32'hFFFFF044, TMR ? 32'h3 : 32'h0);
        store(32'hFFFFF048, 32'h1);
        load("tcnt_0", 32'hFFFFF040, 32'h0);
        tick();
        load("tcnt_1", 32'hFFFFF040, TMR ? 32'h1 : 32'h0);
        tick();
        load("tcnt_2", 32'hFFFFF040, TMR ? 32'h2 : 32'h0);
        tick();
        load("tcnt_3", 32'hFFFFF040, TMR ? 32'h3 : 32'h0);
        chk("irq_pre", {31'd0, timer_irq}, 32'h0);
        tick();
        load("tcnt_wrap", 32'hFFFFF040, 32'h0);
        chk("irq_set", {31'd0, timer_irq}, TMR ? 32'h1 : 32'h0);
        for (int i = 0; i < 3; i++) tick();
        load("tcnt_3b", 32'hFFFFF040, TMR ? 32'h3 : 32'h0);
        store(32'hFFFFF048, 32'h3);
        chk("irq_set_beats_clr", {31'd0, timer_irq}, TMR ? 32'h1 : 32'h0);
        load("tctl_rd", 32'hFFFFF048, TMR ? 32'h3 : 32'h0);
        store(32'hFFFFF048, 32'h2);
        chk("irq_clr", {31'd0, timer_irq}, 32'h0);
        load("tctl_off", 32'hFFFFF048, 32'h0);
        store(32'hFFFFF040, 32'h55);
        load("tcnt_wr", 32'hFFFFF040, TMR ? 32'h55 : 32'h0);

        // Mid-operation reset: timer running, digit index 5
        rst = 1'b1;
        #3;
        @(posedge clk);
        #2;
        rst = 1'b0;
        store(32'hFFFFF060, 32'h00123456);
        store(32'hFFFFF044, 32'd100);
        store(32'hFFFFF048, 32'h1);
        for (int i = 0; i < 18; i++) tick();
        chk("mid_an_d5", {24'd0, seg_an}, 32'hDF);
        load("mid_tcnt_run", 32'hFFFFF040, TMR ? 32'd18 : 32'h0);
        chk("mid_led_pre", {8'd0, led}, 32'h00123456);
        #1;
        rst = 1'b1;
        #1;
        load("mid_tcnt_rst", 32'hFFFFF040, 32'h0);
        chk("mid_irq_rst", {31'd0, timer_irq}, 32'h0);
        chk("mid_an_rst",  {24'd0, seg_an}, 32'hFE);
        chk("mid_led_rst", {8'd0, led}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
